// File: rtl/ppu_sram_arb.sv
// ppu_sram_arb: render/CPU arbiter and strobe sequencer for the 4Kx16 CHR SRAM
module ppu_sram_arb #(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rnd_req,
  input  logic [11:0] i_rnd_addr,
  output logic        o_rnd_ack,
  output logic [15:0] o_rnd_rdata,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [12:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic [11:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  output logic        o_sram_wdata_oe,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n,
  output logic        o_busy
);
  typedef enum logic [2:0] {IDLE, RD, WR, WREC, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, streak_q, streak_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0] wbyte_q, wbyte_d, cpu_rdata_q, cpu_rdata_d;
  logic [15:0] rnd_rdata_q, rnd_rdata_d;
  logic lane_q, lane_d, own_cpu_q, own_cpu_d;
  logic grant_cpu, grant_rnd;
  always_comb begin
    grant_cpu = i_cpu_req && (!i_rnd_req || streak_q == 4'(STARVE_MAX));
    grant_rnd = i_rnd_req && !grant_cpu;
    state_d = state_q;
    cnt_d = cnt_q;
    streak_d = streak_q;
    addr_d = addr_q;
    wbyte_d = wbyte_q;
    lane_d = lane_q;
    own_cpu_d = own_cpu_q;
    rnd_rdata_d = rnd_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      IDLE: if (grant_cpu || grant_rnd) begin
        own_cpu_d = grant_cpu;
        addr_d = grant_cpu ? i_cpu_addr[12:1] : i_rnd_addr;
        lane_d = grant_cpu && i_cpu_addr[0];
        wbyte_d = grant_cpu ? i_cpu_wdata : wbyte_q;
        streak_d = (grant_rnd && i_cpu_req) ? streak_q + 4'd1 : 4'd0;
        state_d = (grant_cpu && i_cpu_we) ? WR : RD;
        cnt_d = (grant_cpu && i_cpu_we) ? 4'(WR_CYC - 1) : 4'(RD_CYC - 1);
      end
      RD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          rnd_rdata_d = own_cpu_q ? rnd_rdata_q : i_sram_rdata;
          cpu_rdata_d = !own_cpu_q ? cpu_rdata_q : (lane_q ? i_sram_rdata[15:8] : i_sram_rdata[7:0]);
        end
      end
      WR: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? WREC : WR;
      end
      WREC: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      streak_q <= '0;
      addr_q <= '0;
      wbyte_q <= '0;
      lane_q <= 1'b0;
      own_cpu_q <= 1'b0;
      rnd_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      streak_q <= streak_d;
      addr_q <= addr_d;
      wbyte_q <= wbyte_d;
      lane_q <= lane_d;
      own_cpu_q <= own_cpu_d;
      rnd_rdata_q <= rnd_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end
  assign o_sram_addr = addr_q;
  assign o_sram_wdata = {wbyte_q, wbyte_q};
  assign o_sram_wdata_oe = state_q == WR || state_q == WREC;
  assign o_sram_oe_n = state_q != RD;
  assign o_sram_we_n = state_q != WR;
  assign o_sram_ub_n = !(state_q == RD || (state_q == WR && lane_q));
  assign o_sram_lb_n = !(state_q == RD || (state_q == WR && !lane_q));
  assign o_rnd_ack = state_q == DONE && !own_cpu_q;
  assign o_cpu_ack = state_q == DONE && own_cpu_q;
  assign o_rnd_rdata = rnd_rdata_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_ppu_sram_arb.sv
// tb_ppu_sram_arb: scoreboard bench for ppu_sram_arb with an SRAM model
module tb_ppu_sram_arb;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_rnd_req = 1'b0, i_cpu_req = 1'b0, i_cpu_we = 1'b0;
  logic [11:0] i_rnd_addr = '0;
  logic [12:0] i_cpu_addr = '0;
  logic [7:0] i_cpu_wdata = '0;
  logic o_rnd_ack, o_cpu_ack, o_sram_wdata_oe, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_busy;
  logic [15:0] o_rnd_rdata, o_sram_wdata, i_sram_rdata;
  logic [7:0] o_cpu_rdata;
  logic [11:0] o_sram_addr;

  ppu_sram_arb #(.RD_CYC(2), .WR_CYC(2), .STARVE_MAX(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rnd_req(i_rnd_req), .i_rnd_addr(i_rnd_addr), .o_rnd_ack(o_rnd_ack), .o_rnd_rdata(o_rnd_rdata),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .o_sram_wdata_oe(o_sram_wdata_oe),
    .i_sram_rdata(i_sram_rdata), .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n),
    .o_sram_ub_n(o_sram_ub_n), .o_sram_lb_n(o_sram_lb_n), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] pat(logic [11:0] a);
    return (a == 12'h123) ? 16'hBEEF : ({a[7:0], a[11:4]} ^ 16'hC3A5);
  endfunction

  logic [15:0] mem [4096];
  logic mem_init = 1'b0;
  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      mem_init <= 1'b1;
    end else if (!o_sram_we_n) begin
      if (!o_sram_ub_n) mem[o_sram_addr][15:8] <= o_sram_wdata[15:8];
      if (!o_sram_lb_n) mem[o_sram_addr][7:0] <= o_sram_wdata[7:0];
    end
  end
  assign i_sram_rdata = mem[o_sram_addr];

  typedef struct packed {logic we; logic [12:0] addr; logic [7:0] data;} cpu_op_t;
  logic [15:0] ref_mem [4096];
  logic [11:0] rnd_todo[$];
  cpu_op_t cpu_todo[$];
  logic [15:0] exp_rnd[$];
  logic [7:0] exp_cpu[$];
  logic ack_log[$];
  int rnd_ack_cyc[$], cpu_ack_cyc[$];
  logic [7:0] cpu_last = '0;
  int errors = 0, checks = 0, cyc = 0, oe_low = 0, we_low = 0;
  logic [11:0] we_addr;
  logic [15:0] we_wdata;
  logic we_ub, we_lb, we_doe;

  task automatic push_rnd(input logic [11:0] a);
    rnd_todo.push_back(a);
    exp_rnd.push_back(ref_mem[a]);
  endtask

  task automatic push_cpu(input logic we, input logic [12:0] a, input logic [7:0] d);
    cpu_todo.push_back({we, a, d});
    if (we) begin
      if (a[0]) ref_mem[a[12:1]][15:8] = d;
      else ref_mem[a[12:1]][7:0] = d;
    end else cpu_last = a[0] ? ref_mem[a[12:1]][15:8] : ref_mem[a[12:1]][7:0];
    exp_cpu.push_back(cpu_last);
  endtask

  task automatic clear_logs();
    ack_log.delete();
    rnd_ack_cyc.delete();
    cpu_ack_cyc.delete();
    oe_low = 0;
    we_low = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    i_rnd_req = rnd_todo.size() != 0;
    if (rnd_todo.size() != 0) i_rnd_addr = rnd_todo[0];
    i_cpu_req = cpu_todo.size() != 0;
    if (cpu_todo.size() != 0) {i_cpu_we, i_cpu_addr, i_cpu_wdata} = cpu_todo[0];
    @(negedge i_clk);
    if (!i_rst) begin
      if (!o_sram_oe_n) begin
        oe_low++;
        checks++;
        if ({o_sram_ub_n, o_sram_lb_n, o_sram_we_n, o_sram_wdata_oe} !== 4'b0010) begin
          errors++;
          $display("FAIL rd_strobes: ub/lb/we_n/doe=%b want 0010", {o_sram_ub_n, o_sram_lb_n, o_sram_we_n, o_sram_wdata_oe});
        end
      end
      if (!o_sram_we_n) begin
        we_low++;
        we_addr = o_sram_addr;
        we_wdata = o_sram_wdata;
        we_ub = o_sram_ub_n;
        we_lb = o_sram_lb_n;
        we_doe = o_sram_wdata_oe;
      end
      if (o_rnd_ack || o_cpu_ack) begin
        checks++;
        if (o_rnd_ack && o_cpu_ack) begin
          errors++;
          $display("FAIL both_acks: rnd=%b cpu=%b want one", o_rnd_ack, o_cpu_ack);
        end
      end
      if (o_rnd_ack) begin
        ack_log.push_back(1'b0);
        rnd_ack_cyc.push_back(cyc);
        if (rnd_todo.size() != 0) void'(rnd_todo.pop_front());
        checks++;
        if (exp_rnd.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected_ack: rdata=%h want no ack", o_rnd_rdata);
        end else begin
          logic [15:0] e;
          e = exp_rnd.pop_front();
          if (o_rnd_rdata !== e) begin
            errors++;
            $display("FAIL rnd_rdata: got %h want %h", o_rnd_rdata, e);
          end
        end
      end
      if (o_cpu_ack) begin
        ack_log.push_back(1'b1);
        cpu_ack_cyc.push_back(cyc);
        if (cpu_todo.size() != 0) void'(cpu_todo.pop_front());
        checks++;
        if (exp_cpu.size() == 0) begin
          errors++;
          $display("FAIL cpu_unexpected_ack: rdata=%h want no ack", o_cpu_rdata);
        end else begin
          logic [7:0] e;
          e = exp_cpu.pop_front();
          if (o_cpu_rdata !== e) begin
            errors++;
            $display("FAIL cpu_rdata: got %h want %h", o_cpu_rdata, e);
          end
        end
      end
    end
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rnd_todo.size() == 0 && cpu_todo.size() == 0 && !o_busy) break;
      step();
    end
    checks++;
    if (rnd_todo.size() != 0 || cpu_todo.size() != 0 || o_busy) begin
      errors++;
      $display("FAIL timeout: pending rnd=%0d cpu=%0d busy=%b want all done", rnd_todo.size(), cpu_todo.size(), o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    checks++;
    if ({o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_sram_wdata_oe, o_rnd_ack, o_cpu_ack, o_busy} !== 8'b11110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 11110000", {o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_sram_wdata_oe, o_rnd_ack, o_cpu_ack, o_busy});
    end
    checks++;
    if ({o_sram_addr, o_sram_wdata, o_rnd_rdata, o_cpu_rdata} !== 52'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {o_sram_addr, o_sram_wdata, o_rnd_rdata, o_cpu_rdata});
    end
    i_rst = 1'b0;
    cpu_last = '0;
    step();
  endtask

  task automatic test_render_read();
    int start;
    clear_logs();
    push_rnd(12'h123);
    start = cyc + 1;
    run_idle(30);
    checks++;
    if (rnd_ack_cyc.size() != 1 || rnd_ack_cyc[0] != start + 3) begin
      errors++;
      $display("FAIL rnd_latency: got %0d acks, first at +%0d want 1 at +3", rnd_ack_cyc.size(), rnd_ack_cyc.size() ? rnd_ack_cyc[0] - start : -1);
    end
    checks++;
    if (oe_low != 2) begin
      errors++;
      $display("FAIL rnd_oe_cycles: got %0d want 2", oe_low);
    end
    checks++;
    if (o_rnd_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rnd_hold: got %h want beef", o_rnd_rdata);
    end
  endtask

  task automatic test_cpu_write();
    int start;
    clear_logs();
    push_cpu(1'b1, 13'h0201, 8'h5A);
    start = cyc + 1;
    run_idle(30);
    checks++;
    if (cpu_ack_cyc.size() != 1 || cpu_ack_cyc[0] != start + 4) begin
      errors++;
      $display("FAIL wr_latency: got %0d acks, first at +%0d want 1 at +4", cpu_ack_cyc.size(), cpu_ack_cyc.size() ? cpu_ack_cyc[0] - start : -1);
    end
    checks++;
    if ({we_low, we_addr, we_wdata, we_ub, we_lb, we_doe} !== {32'd2, 12'h100, 16'h5A5A, 3'b011}) begin
      errors++;
      $display("FAIL wr_strobes: we_cycles=%0d addr=%h wdata=%h ub=%b lb=%b doe=%b want 2 100 5a5a 0 1 1", we_low, we_addr, we_wdata, we_ub, we_lb, we_doe);
    end
    push_cpu(1'b0, 13'h0201, 8'h00);
    push_cpu(1'b0, 13'h0200, 8'h00);
    push_cpu(1'b1, 13'h0400, 8'h77);
    push_cpu(1'b0, 13'h0400, 8'h00);
    push_cpu(1'b0, 13'h0401, 8'h00);
    run_idle(80);
    checks++;
    if (mem[12'h200] !== {pat(12'h200)[15:8], 8'h77}) begin
      errors++;
      $display("FAIL wr_lane_lo: got %h want %h", mem[12'h200], {pat(12'h200)[15:8], 8'h77});
    end
  endtask

  task automatic test_same_cycle();
    clear_logs();
    push_rnd(12'h010);
    push_cpu(1'b0, 13'h0022, 8'h00);
    run_idle(40);
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 1'b0 || ack_log[1] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_order: got %0d acks first_cpu=%b want render then cpu", ack_log.size(), ack_log.size() ? ack_log[0] : 1'bx);
    end
  endtask

  task automatic test_starve();
    logic [6:0] got;
    clear_logs();
    for (int i = 0; i < 6; i++) push_rnd(12'h020 + 12'(i));
    push_cpu(1'b0, 13'h0041, 8'h00);
    run_idle(100);
    got = '0;
    foreach (ack_log[i]) got = {got[5:0], ack_log[i]};
    checks++;
    if (ack_log.size() != 7 || got !== 7'b0000100) begin
      errors++;
      $display("FAIL starve_order: got %b (%0d acks) want 0000100", got, ack_log.size());
    end
    clear_logs();
    for (int i = 0; i < 5; i++) push_rnd(12'h030 + 12'(i));
    push_cpu(1'b1, 13'h0061, 8'h3C);
    run_idle(100);
    got = '0;
    foreach (ack_log[i]) got = {got[5:0], ack_log[i]};
    checks++;
    if (ack_log.size() != 6 || got[5:0] !== 6'b000010) begin
      errors++;
      $display("FAIL starve_restart: got %b (%0d acks) want 000010", got[5:0], ack_log.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    push_cpu(1'b1, 13'h0305, 8'hC3);
    for (int i = 0; i < 20 && we_low < 1; i++) step();
    step();
    checks++;
    if (o_sram_we_n !== 1'b0 || we_low != 2) begin
      errors++;
      $display("FAIL mid_we_low: we_n=%b cycles=%0d want 0 2", o_sram_we_n, we_low);
    end
    i_rst = 1'b1;
    cpu_last = '0;
    exp_cpu[0] = 8'h00;
    step();
    checks++;
    if ({o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_sram_wdata_oe, o_cpu_ack, o_rnd_ack} !== 6'b111000) begin
      errors++;
      $display("FAIL mid_reset_strobes: we_n/ub/lb/doe/acks=%b want 111000", {o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_sram_wdata_oe, o_cpu_ack, o_rnd_ack});
    end
    i_rst = 1'b0;
    checks++;
    if (ack_log.size() != 0) begin
      errors++;
      $display("FAIL mid_no_ack: got %0d acks want 0", ack_log.size());
    end
    run_idle(40);
    checks++;
    if (cpu_ack_cyc.size() != 1 || mem[12'h182][15:8] !== 8'hC3) begin
      errors++;
      $display("FAIL mid_regrant: acks=%0d hi=%h want 1 c3", cpu_ack_cyc.size(), mem[12'h182][15:8]);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int i = 0; i < 4; i++) push_rnd(12'(i));
    run_idle(60);
    checks++;
    if (rnd_ack_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", rnd_ack_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rnd_ack_cyc[i] - rnd_ack_cyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d want 4", rnd_ack_cyc[i] - rnd_ack_cyc[i-1]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
    test_reset();
    test_render_read();
    test_cpu_write();
    test_same_cycle();
    test_starve();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
